// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button-driven counter: repeat FSM state
// encodings, channel role indices and the counter step kinds.
// No ports.
// ---------------------------------------------------------------------------
package btn_pkg;

  // Repeat FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Channel roles
  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_CLR = 2;

  // Resolved counter action for one cycle
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_CLR  = 2'd3
  } step_e;

endpackage

// File: rtl/btn_ctr_if.sv
// ---------------------------------------------------------------------------
// btn_ctr_if
// Bundles the raw button inputs and the conditioned/counter outputs of
// btn_ctr.
//   btn   : raw button levels (asynchronous to clk)
//   level : debounced levels
//   press : one-cycle pulse per debounced rising edge
//   count : counter value
//   limit : one-cycle pulse when a step wraps or is clamped
// Modports: master drives btn (board/bench side), slave is the counter.
// ---------------------------------------------------------------------------
interface btn_ctr_if #(
  parameter int NBTN  = 5,
  parameter int WIDTH = 16
);

  logic [NBTN-1:0]  btn;
  logic [NBTN-1:0]  level;
  logic [NBTN-1:0]  press;
  logic [WIDTH-1:0] count;
  logic             limit;

  modport master (output btn, input level, press, count, limit);
  modport slave  (input btn, output level, press, count, limit);

endinterface

// File: rtl/btn_chan.sv
// ---------------------------------------------------------------------------
// btn_chan
// One button channel: two-flop synchroniser, debouncer, rising-edge detector
// and auto-repeat generator.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   raw   : raw button level
//   level : debounced level
//   press : one-cycle pulse on the first cycle level is 1
//   rep   : one-cycle auto-repeat pulse while the button is held
//
// Repeat FSM states:
//   state     | meaning
//   ST_IDLE   | button released, or auto-repeat disabled
//   ST_DELAY  | held, waiting REPEAT_DELAY cycles for the first repeat
//   ST_REPEAT | held, pulsing rep every REPEAT_PERIOD cycles
// ---------------------------------------------------------------------------
module btn_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = 50000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rep
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_TC = DBW'(DB_CYCLES - 1);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_TC = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RP_TC = RW'(REPEAT_PERIOD - 1);
  localparam bit REP_EN = (REPEAT_DELAY > 0);

  logic           s1;
  logic           s2;
  logic           level_d;
  logic [DBW-1:0] db_cnt;
  logic [1:0]     state;
  logic [RW-1:0]  rcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // The counter only runs while s2 disagrees with level, so any
  // disagreement shorter than DB_CYCLES cycles is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level   <= 1'b0;
      level_d <= 1'b0;
      db_cnt  <= '0;
    end else begin
      level_d <= level;
      if (s2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        level  <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign press = level & ~level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else if (!level) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (press && REP_EN) begin
            state <= ST_DELAY;
            rcnt  <= '0;
          end
        end
        ST_DELAY: begin
          if (rcnt == RD_TC) begin
            state <= ST_REPEAT;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (rcnt == RP_TC) rcnt <= '0;
          else               rcnt <= rcnt + RW'(1);
        end
        default: begin
          state <= ST_IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end

  // Gated by level so a release never produces a trailing repeat.
  assign rep = level & (((state == ST_DELAY)  && (rcnt == RD_TC)) ||
                        ((state == ST_REPEAT) && (rcnt == RP_TC)));

endmodule

// File: rtl/btn_ctr.sv
// ---------------------------------------------------------------------------
// btn_ctr
// Button-driven up/down/clear counter. Each raw button goes through a
// btn_chan; channels 0/1 (inc/dec) auto-repeat, channel 2 clears, higher
// channels are report-only.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : btn_ctr_if slave (btn in; level, press, count, limit out)
// ---------------------------------------------------------------------------
module btn_ctr
  import btn_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NBTN          = 5,
  parameter int DB_CYCLES     = 50000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000,
  parameter bit SATURATE      = 1'b0
) (
  input logic        clk,
  input logic        rst,
  btn_ctr_if.slave   bus
);

  logic [NBTN-1:0]  level;
  logic [NBTN-1:0]  press;
  logic [1:0]       rep;
  logic [WIDTH-1:0] count;
  logic             limit;
  logic             up;
  logic             dn;
  logic             clr;
  logic             at_max;
  logic             at_min;
  step_e            step;

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    if (i < 2) begin : g_rep
      btn_chan #(
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn[i]),
        .level (level[i]),
        .press (press[i]),
        .rep   (rep[i])
      );
    end else begin : g_norep
      logic rep_unused;
      btn_chan #(
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_DELAY  (0),
        .REPEAT_PERIOD (REPEAT_PERIOD)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn[i]),
        .level (level[i]),
        .press (press[i]),
        .rep   (rep_unused)
      );
    end
  end

  assign up     = press[BTN_INC] | rep[BTN_INC];
  assign dn     = press[BTN_DEC] | rep[BTN_DEC];
  assign clr    = press[BTN_CLR];
  assign at_max = (count == {WIDTH{1'b1}});
  assign at_min = (count == '0);

  // Clear dominates; opposing up/down cancel to no step at all.
  always_comb begin
    step = STEP_NONE;
    if (clr)            step = STEP_CLR;
    else if (up && !dn) step = STEP_UP;
    else if (dn && !up) step = STEP_DN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      limit <= 1'b0;
    end else begin
      limit <= 1'b0;
      case (step)
        STEP_CLR: count <= '0;
        STEP_UP: begin
          if (at_max) begin
            limit <= 1'b1;
            if (!SATURATE) count <= '0;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        STEP_DN: begin
          if (at_min) begin
            limit <= 1'b1;
            if (!SATURATE) count <= {WIDTH{1'b1}};
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.level = level;
  assign bus.press = press;
  assign bus.count = count;
  assign bus.limit = limit;

endmodule

// File: tb/tb_btn_ctr.sv
module tb_btn_ctr;

  localparam int W  = 4;
  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;

  int checks   = 0;
  int failures = 0;

  int           lim_a;
  int           lim_b;
  logic [W-1:0] lim_a_val;
  logic [W-1:0] lim_b_val;
  int           press0_a;

  btn_ctr_if #(.NBTN(N), .WIDTH(W)) bus_a ();
  btn_ctr_if #(.NBTN(N), .WIDTH(W)) bus_b ();

  assign bus_a.btn = btn;
  assign bus_b.btn = btn;

  btn_ctr #(
    .WIDTH(W), .NBTN(N), .DB_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SATURATE(1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  btn_ctr #(
    .WIDTH(W), .NBTN(N), .DB_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .SATURATE(1'b1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and record pulse activity there.
  task automatic tick();
    @(negedge clk);
    if (bus_a.limit === 1'b1) begin lim_a++; lim_a_val = bus_a.count; end
    if (bus_b.limit === 1'b1) begin lim_b++; lim_b_val = bus_b.count; end
    if (bus_a.press[0] === 1'b1) press0_a++;
  endtask

  task automatic clear_obs();
    lim_a = 0; lim_b = 0; lim_a_val = '0; lim_b_val = '0; press0_a = 0;
  endtask

  task automatic do_reset();
    btn = '0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    clear_obs();
  endtask

  // Short press: level stays high 8 cycles, below the repeat delay.
  task automatic tap(input int idx);
    btn[idx] = 1'b1;
    repeat (8) tick();
    btn[idx] = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    btn = '0;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus_a.level !== '0) begin failures++; $display("FAIL reset_level actual=%b expected=%b", bus_a.level, 5'b0); end
    checks++; if (bus_a.press !== '0) begin failures++; $display("FAIL reset_press actual=%b expected=%b", bus_a.press, 5'b0); end
    checks++; if (bus_a.count !== 4'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", bus_a.count); end
    checks++; if (bus_a.limit !== 1'b0) begin failures++; $display("FAIL reset_limit actual=%b expected=0", bus_a.limit); end
    checks++; if (bus_b.count !== 4'd0) begin failures++; $display("FAIL reset_count_sat actual=%0d expected=0", bus_b.count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_debounce();
    int seen;
    int rise;
    do_reset();
    btn[0] = 1'b1;
    repeat (3) tick();
    btn[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_a.level[0] === 1'b1) seen = 1;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL glitch_level actual=%0d expected=0", seen); end
    checks++; if (bus_a.count !== 4'd0) begin failures++; $display("FAIL glitch_count actual=%0d expected=0", bus_a.count); end

    clear_obs();
    btn[0] = 1'b1;
    rise = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rise == 0 && bus_a.level[0] === 1'b1) rise = i;
      if (i == 9) btn[0] = 1'b0;
    end
    checks++; if (rise !== 6) begin failures++; $display("FAIL debounce_latency actual=%0d expected=6", rise); end
    checks++; if (press0_a !== 1) begin failures++; $display("FAIL debounce_press_count actual=%0d expected=1", press0_a); end
    checks++; if (bus_a.count !== 4'd1) begin failures++; $display("FAIL debounce_count actual=%0d expected=1", bus_a.count); end
  endtask

  task automatic test_auto_repeat();
    logic [W-1:0] c10, c11, c14, c30;
    logic         lvl30;
    do_reset();
    c10 = 'x; c11 = 'x; c14 = 'x; c30 = 'x; lvl30 = 'x;
    btn[0] = 1'b1;
    repeat (6) tick();
    checks++; if (bus_a.press[0] !== 1'b1) begin failures++; $display("FAIL repeat_first_press actual=%b expected=1", bus_a.press[0]); end
    for (int j = 1; j <= 36; j++) begin
      tick();
      if (j == 10) c10 = bus_a.count;
      if (j == 11) c11 = bus_a.count;
      if (j == 14) c14 = bus_a.count;
      if (j == 30) begin c30 = bus_a.count; lvl30 = bus_a.level[0]; end
      if (j == 24) btn[0] = 1'b0;
    end
    repeat (20) tick();
    checks++; if (c10 !== 4'd1) begin failures++; $display("FAIL repeat_before_first actual=%0d expected=1", c10); end
    checks++; if (c11 !== 4'd2) begin failures++; $display("FAIL repeat_first actual=%0d expected=2", c11); end
    checks++; if (c14 !== 4'd3) begin failures++; $display("FAIL repeat_second actual=%0d expected=3", c14); end
    checks++; if (lvl30 !== 1'b0) begin failures++; $display("FAIL repeat_release_level actual=%b expected=0", lvl30); end
    checks++; if (c30 !== 4'd8) begin failures++; $display("FAIL repeat_total actual=%0d expected=8", c30); end
    checks++; if (bus_a.count !== 4'd8) begin failures++; $display("FAIL repeat_after_release actual=%0d expected=8", bus_a.count); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (15) tap(0);
    checks++; if (bus_a.count !== 4'd15) begin failures++; $display("FAIL wrap_ramp actual=%0d expected=15", bus_a.count); end
    checks++; if (lim_a !== 0) begin failures++; $display("FAIL wrap_ramp_limit actual=%0d expected=0", lim_a); end
    clear_obs();
    tap(0);
    checks++; if (bus_a.count !== 4'd0) begin failures++; $display("FAIL wrap_up actual=%0d expected=0", bus_a.count); end
    checks++; if (lim_a !== 1) begin failures++; $display("FAIL wrap_up_limit actual=%0d expected=1", lim_a); end
    checks++; if (lim_a_val !== 4'd0) begin failures++; $display("FAIL wrap_up_align actual=%0d expected=0", lim_a_val); end
    clear_obs();
    tap(1);
    checks++; if (bus_a.count !== 4'd15) begin failures++; $display("FAIL wrap_dn actual=%0d expected=15", bus_a.count); end
    checks++; if (lim_a !== 1) begin failures++; $display("FAIL wrap_dn_limit actual=%0d expected=1", lim_a); end
    checks++; if (lim_a_val !== 4'd15) begin failures++; $display("FAIL wrap_dn_align actual=%0d expected=15", lim_a_val); end
  endtask

  task automatic test_saturate();
    do_reset();
    tap(1);
    checks++; if (bus_b.count !== 4'd0) begin failures++; $display("FAIL sat_low actual=%0d expected=0", bus_b.count); end
    checks++; if (lim_b !== 1) begin failures++; $display("FAIL sat_low_limit actual=%0d expected=1", lim_b); end
    clear_obs();
    repeat (15) tap(0);
    checks++; if (bus_b.count !== 4'd15) begin failures++; $display("FAIL sat_ramp actual=%0d expected=15", bus_b.count); end
    checks++; if (lim_b !== 0) begin failures++; $display("FAIL sat_ramp_limit actual=%0d expected=0", lim_b); end
    clear_obs();
    tap(0);
    checks++; if (bus_b.count !== 4'd15) begin failures++; $display("FAIL sat_high actual=%0d expected=15", bus_b.count); end
    checks++; if (lim_b !== 1) begin failures++; $display("FAIL sat_high_limit actual=%0d expected=1", lim_b); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    repeat (5) tap(0);
    checks++; if (bus_a.count !== 4'd5) begin failures++; $display("FAIL simul_setup actual=%0d expected=5", bus_a.count); end
    clear_obs();
    btn[0] = 1'b1; btn[1] = 1'b1;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
    checks++; if (bus_a.count !== 4'd5) begin failures++; $display("FAIL simul_updn actual=%0d expected=5", bus_a.count); end
    checks++; if (lim_a !== 0) begin failures++; $display("FAIL simul_updn_limit actual=%0d expected=0", lim_a); end
    btn[0] = 1'b1; btn[2] = 1'b1;
    repeat (8) tick();
    btn = '0;
    repeat (8) tick();
    checks++; if (bus_a.count !== 4'd0) begin failures++; $display("FAIL simul_clr actual=%0d expected=0", bus_a.count); end
    checks++; if (lim_a !== 0) begin failures++; $display("FAIL simul_clr_limit actual=%0d expected=0", lim_a); end
  endtask

  task automatic test_reset_mid_repeat();
    int           rise;
    logic [W-1:0] c1, c10, c11;
    do_reset();
    c1 = 'x; c10 = 'x; c11 = 'x;
    btn[0] = 1'b1;
    repeat (6) tick();
    repeat (27) tick();
    checks++; if (bus_a.count !== 4'd7) begin failures++; $display("FAIL midrep_count actual=%0d expected=7", bus_a.count); end
    rst = 1'b1;
    #1;
    checks++; if (bus_a.level !== '0) begin failures++; $display("FAIL midrep_rst_level actual=%b expected=%b", bus_a.level, 5'b0); end
    checks++; if (bus_a.press !== '0) begin failures++; $display("FAIL midrep_rst_press actual=%b expected=%b", bus_a.press, 5'b0); end
    checks++; if (bus_a.count !== 4'd0) begin failures++; $display("FAIL midrep_rst_count actual=%0d expected=0", bus_a.count); end
    checks++; if (bus_a.limit !== 1'b0) begin failures++; $display("FAIL midrep_rst_limit actual=%b expected=0", bus_a.limit); end
    tick();
    rst = 1'b0;
    rise = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (rise == 0 && bus_a.level[0] === 1'b1) rise = i;
      if (rise != 0 && i == rise + 1)  c1  = bus_a.count;
      if (rise != 0 && i == rise + 10) c10 = bus_a.count;
      if (rise != 0 && i == rise + 11) c11 = bus_a.count;
    end
    btn = '0;
    repeat (10) tick();
    checks++; if (rise !== 6) begin failures++; $display("FAIL midrep_relatency actual=%0d expected=6", rise); end
    checks++; if (c1 !== 4'd1) begin failures++; $display("FAIL midrep_press_count actual=%0d expected=1", c1); end
    checks++; if (c10 !== 4'd1) begin failures++; $display("FAIL midrep_pre_repeat actual=%0d expected=1", c10); end
    checks++; if (c11 !== 4'd2) begin failures++; $display("FAIL midrep_first_repeat actual=%0d expected=2", c11); end
  endtask

  initial begin
    btn = '0;
    rst = 1'b1;
    clear_obs();
    test_reset();
    test_debounce();
    test_auto_repeat();
    test_wrap();
    test_saturate();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
